// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl
//
// Sequencer for a multi-round reaction-time test. A session runs
// 2^LOG2_ROUNDS rounds. Each round waits iSW plus a pseudo-random number of
// time-base ticks, lights the stimulus LED, and times the subject's stop
// press in ticks. Last, best and average reaction times are published.
//
// Optional feature macro: FALSE_START_EN
//   defined   : a stop press while waiting (DELAY) is a false start; the block
//               enters FAULT for GAP_TICKS ticks and repeats the same round.
//   undefined : stop presses in DELAY are ignored, oFault is tied low.
//
// Ports
//   iClk    in   system clock, rising edge
//   iRst    in   asynchronous active-low reset
//   iTick   in   one-cycle time-base strobe; all delay/reaction timing uses it
//   iStart  in   start a session (honoured in IDLE or DONE only)
//   iStop   in   stop button (synchronous, debounced); rising edge used
//   iSW     in   base delay in ticks
//   oLed    out  stimulus LED
//   oBusy   out  session in progress (DELAY, REACT, GAP, FAULT)
//   oDone   out  session finished, results held
//   oFault  out  false-start indicator
//   oRound  out  current round index
//   oTime   out  last recorded reaction time
//   oBest   out  minimum reaction time this session
//   oAvg    out  session average reaction time
//   oState  out  debug view of the sequencer state encoding

module reaction_session_ctrl #(
  parameter int LOG2_ROUNDS = 2,
  parameter int TIME_W      = 8,
  parameter int DELAY_W     = 4,
  parameter int GAP_TICKS   = 2
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iTick,
  input  logic                   iStart,
  input  logic                   iStop,
  input  logic [DELAY_W-1:0]     iSW,
  output logic                   oLed,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oFault,
  output logic [LOG2_ROUNDS-1:0] oRound,
  output logic [TIME_W-1:0]      oTime,
  output logic [TIME_W-1:0]      oBest,
  output logic [TIME_W-1:0]      oAvg,
  output logic [2:0]             oState
);

  localparam int SUM_W = TIME_W + LOG2_ROUNDS;
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [TIME_W-1:0]      TIME_MAX    = '1;
  localparam logic [TIME_W-1:0]      TIME_MAX_M1 = TIME_MAX - 1'b1;
  localparam logic [LOG2_ROUNDS-1:0] LAST_ROUND  = '1;
  localparam logic [GAP_W-1:0]       GAP_LOAD    = GAP_W'(GAP_TICKS);
  localparam logic [GAP_W-1:0]       GAP_ONE     = GAP_W'(1);
  localparam logic [DELAY_W:0]       DELAY_ONE   = (DELAY_W+1)'(1);

`ifdef FALSE_START_EN
  typedef enum logic [2:0] {IDLE, DELAY, REACT, GAP, DONE, FAULT} state_t;
`else
  typedef enum logic [2:0] {IDLE, DELAY, REACT, GAP, DONE} state_t;
`endif

  state_t               rState;
  logic [7:0]           rLfsr;
  logic                 rStopD;
  logic [DELAY_W:0]     rDelayCnt;
  logic [TIME_W-1:0]    rCount;
  logic [GAP_W-1:0]     rGapCnt;
  logic [SUM_W-1:0]     rSum;

  logic                 lfsrFb;
  logic                 stopEdge;
  logic [DELAY_W:0]     delayLoad;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running every clock so the
  // per-round delay depends on when the subject started the session.
  assign lfsrFb = rLfsr[7] ^ rLfsr[5] ^ rLfsr[4] ^ rLfsr[3];

  // One extra bit so iSW + 7 + 1 cannot wrap; the +1 keeps the delay >= 1.
  assign delayLoad = {1'b0, iSW} + (DELAY_W+1)'(rLfsr[2:0]) + DELAY_ONE;

  // A press already held on REACT entry has no rising edge and is ignored.
  assign stopEdge = iStop & ~rStopD;

  assign oState = rState;

`ifndef FALSE_START_EN
  assign oFault = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rState    <= IDLE;
      rLfsr     <= 8'hA5;
      rStopD    <= 1'b0;
      rDelayCnt <= '0;
      rCount    <= '0;
      rGapCnt   <= '0;
      rSum      <= '0;
      oLed      <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
`ifdef FALSE_START_EN
      oFault    <= 1'b0;
`endif
      oRound    <= '0;
      oTime     <= '0;
      oBest     <= '1;
      oAvg      <= '0;
    end else begin
      rLfsr  <= {rLfsr[6:0], lfsrFb};
      rStopD <= iStop;

      case (rState)
        IDLE, DONE: begin
          if (iStart) begin
            rDelayCnt <= delayLoad;
            oRound    <= '0;
            rSum      <= '0;
            oBest     <= '1;
            oDone     <= 1'b0;
            oBusy     <= 1'b1;
            oLed      <= 1'b0;
            rState    <= DELAY;
          end
        end

        DELAY: begin
`ifdef FALSE_START_EN
          if (stopEdge) begin
            oFault  <= 1'b1;
            oLed    <= 1'b0;
            rGapCnt <= GAP_LOAD;
            rState  <= FAULT;
          end else
`endif
          if (iTick) begin
            if (rDelayCnt == DELAY_ONE) begin
              oLed   <= 1'b1;
              rCount <= '0;
              rState <= REACT;
            end else begin
              rDelayCnt <= rDelayCnt - 1'b1;
            end
          end
        end

        REACT: begin
          // The stop press beats a coincident tick: record the un-incremented count.
          if (stopEdge) begin
            oTime   <= rCount;
            rSum    <= rSum + SUM_W'(rCount);
            if (rCount < oBest) oBest <= rCount;
            oLed    <= 1'b0;
            rGapCnt <= GAP_LOAD;
            rState  <= GAP;
          end else if (iTick) begin
            if (rCount == TIME_MAX_M1) begin
              // Timeout: saturated value is recorded; it can never lower oBest.
              rCount  <= TIME_MAX;
              oTime   <= TIME_MAX;
              rSum    <= rSum + SUM_W'(TIME_MAX);
              oLed    <= 1'b0;
              rGapCnt <= GAP_LOAD;
              rState  <= GAP;
            end else begin
              rCount <= rCount + 1'b1;
            end
          end
        end

        GAP: begin
          if (iTick) begin
            if (rGapCnt == GAP_ONE) begin
              if (oRound == LAST_ROUND) begin
                oAvg   <= rSum[SUM_W-1:LOG2_ROUNDS];
                oDone  <= 1'b1;
                oBusy  <= 1'b0;
                rState <= DONE;
              end else begin
                oRound    <= oRound + 1'b1;
                rDelayCnt <= delayLoad;
                rState    <= DELAY;
              end
            end else begin
              rGapCnt <= rGapCnt - 1'b1;
            end
          end
        end

`ifdef FALSE_START_EN
        FAULT: begin
          // Same round is retried; nothing was recorded for the aborted attempt.
          if (iTick) begin
            if (rGapCnt == GAP_ONE) begin
              oFault    <= 1'b0;
              rDelayCnt <= delayLoad;
              rState    <= DELAY;
            end else begin
              rGapCnt <= rGapCnt - 1'b1;
            end
          end
        end
`endif

        default: begin
          oLed   <= 1'b0;
          oBusy  <= 1'b0;
          rState <= IDLE;
        end
      endcase
    end
  end

endmodule
